// File: rtl/mro_age_tracker.sv
// Tracks allocation age of ENTRIES slots and selects the oldest eligible slot per channel.
// Latency: alloc/free take effect at the next rising edge; oldest-select is combinational.
// Backpressure: alloc is denied while full; a channel's slot is freed only when its pick_rdy is high.
module mro_age_tracker #(
    parameter  int ENTRIES = 8,
    parameter  int NUM_CH  = 2,
    localparam int ENC_W   = $clog2(ENTRIES)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_alloc_req,
    output logic                                o_alloc_gnt,
    output logic [ENTRIES-1:0]                  o_alloc_vec,
    input  logic [ENTRIES-1:0]                  i_dealloc,
    input  logic [NUM_CH-1:0][ENTRIES-1:0]      i_mask,
    input  logic [NUM_CH-1:0]                   i_pick_rdy,
    output logic [NUM_CH-1:0]                   o_oldest_vld,
    output logic [NUM_CH-1:0][ENTRIES-1:0]      o_oldest,
    output logic [NUM_CH-1:0][ENC_W-1:0]        o_oldest_enc,
    output logic [ENTRIES-1:0]                  o_valid,
    output logic [ENC_W:0]                      o_count,
    output logic                                o_full,
    output logic                                o_empty
);

    // r_older[i][j] = 1 when slot i was allocated before slot j (both live)
    logic [ENTRIES-1:0]                 r_valid;
    logic [ENTRIES-1:0][ENTRIES-1:0]    r_older;

    logic [ENTRIES-1:0]                 w_lowest_free;
    logic [ENTRIES-1:0]                 w_alloc_vec;
    logic                               w_alloc_gnt;
    logic [ENC_W:0]                     w_count;
    logic                               w_full;
    logic [NUM_CH-1:0]                  w_vld;
    logic [NUM_CH-1:0][ENTRIES-1:0]     w_oldest;
    logic [NUM_CH-1:0][ENC_W-1:0]       w_enc;
    logic [ENTRIES-1:0]                 w_taken;
    logic [ENTRIES-1:0]                 w_cand;
    logic                               w_blocked;
    logic [ENTRIES-1:0]                 w_pick;
    logic [ENTRIES-1:0]                 w_free;
    logic [ENTRIES-1:0][ENTRIES-1:0]    w_older_nxt;

    // Occupancy count and lowest-index free slot, both from pre-edge valid only
    always_comb begin
        w_count       = '0;
        w_lowest_free = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            w_count = w_count + (ENC_W+1)'(r_valid[k]);
        end
        // Descending scan so the lowest free index is written last and wins
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (!r_valid[k]) begin
                w_lowest_free    = '0;
                w_lowest_free[k] = 1'b1;
            end
        end
        w_full      = (w_count == (ENC_W+1)'(ENTRIES));
        w_alloc_gnt = i_alloc_req & ~w_full;
        w_alloc_vec = w_alloc_gnt ? w_lowest_free : '0;
    end

    // Per-channel oldest select; lower channels claim their slot first
    always_comb begin
        w_taken   = '0;
        w_cand    = '0;
        w_blocked = 1'b0;
        w_oldest  = '0;
        w_enc     = '0;
        w_vld     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cand = r_valid & i_mask[c] & ~w_taken;
            for (int k = 0; k < ENTRIES; k++) begin
                w_blocked = 1'b0;
                for (int i = 0; i < ENTRIES; i++) begin
                    if (w_cand[i] && r_older[i][k]) begin
                        w_blocked = 1'b1;
                    end
                end
                if (w_cand[k] && !w_blocked) begin
                    w_oldest[c][k] = 1'b1;
                    w_enc[c]       = ENC_W'(k);
                end
            end
            w_vld[c] = |w_cand;
            w_taken  = w_taken | w_oldest[c];
        end
    end

    // Free vector: external deallocs plus accepted picks, restricted to live slots
    always_comb begin
        w_pick = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_pick_rdy[c]) begin
                w_pick = w_pick | w_oldest[c];
            end
        end
        w_free = (i_dealloc | w_pick) & r_valid;
    end

    // Next age matrix: new slot is younger than every live slot; freed rows/cols cleared
    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (w_alloc_vec[j] && (i != j)) begin
                    w_older_nxt[i][j] = r_valid[i];
                end
                if (w_alloc_vec[i] || w_free[i] || w_free[j] || (i == j)) begin
                    w_older_nxt[i][j] = 1'b0;
                end
            end
        end
    end

    // State update; reset overrides any same-cycle alloc or free
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_older <= '0;
        end else begin
            r_valid <= (r_valid & ~w_free) | w_alloc_vec;
            r_older <= w_older_nxt;
        end
    end

    assign o_alloc_gnt  = w_alloc_gnt;
    assign o_alloc_vec  = w_alloc_vec;
    assign o_oldest_vld = w_vld;
    assign o_oldest     = w_oldest;
    assign o_oldest_enc = w_enc;
    assign o_valid      = r_valid;
    assign o_count      = w_count;
    assign o_full       = w_full;
    assign o_empty      = (w_count == '0);

endmodule

// File: tb/tb_mro_age_tracker.sv
// Directed bench for mro_age_tracker with ENTRIES=4, NUM_CH=2.
// Inputs change on the falling edge; outputs are checked 1ns later.
// Each scenario task checks its own expected values inline.
module tb_mro_age_tracker;

    logic            clk;
    logic            rst;
    logic            alloc_req;
    logic            alloc_gnt;
    logic [3:0]      alloc_vec;
    logic [3:0]      dealloc;
    logic [1:0][3:0] mask;
    logic [1:0]      pick_rdy;
    logic [1:0]      oldest_vld;
    logic [1:0][3:0] oldest;
    logic [1:0][1:0] oldest_enc;
    logic [3:0]      valid;
    logic [2:0]      count;
    logic            full;
    logic            empty;

    int checks = 0;
    int errors = 0;

    mro_age_tracker #(.ENTRIES(4), .NUM_CH(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_alloc_req  (alloc_req),
        .o_alloc_gnt  (alloc_gnt),
        .o_alloc_vec  (alloc_vec),
        .i_dealloc    (dealloc),
        .i_mask       (mask),
        .i_pick_rdy   (pick_rdy),
        .o_oldest_vld (oldest_vld),
        .o_oldest     (oldest),
        .o_oldest_enc (oldest_enc),
        .o_valid      (valid),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling edge (one rising edge has passed)
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alloc_req = 1'b0;
        dealloc   = '0;
        mask      = '0;
        pick_rdy  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            tick();
        end
        alloc_req = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        alloc_req = 1'b1;
        mask      = {4'b1111, 4'b1111};
        #1;
        checks++;
        if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b exp 1", alloc_gnt); end
        checks++;
        if (alloc_vec !== 4'b0001) begin errors++; $display("FAIL reset_vec got %b exp 0001", alloc_vec); end
        checks++;
        if (oldest_vld !== 2'b00) begin errors++; $display("FAIL reset_oldest_vld got %b exp 00", oldest_vld); end
        checks++;
        if (oldest !== 8'h00) begin errors++; $display("FAIL reset_oldest got %h exp 00", oldest); end
        checks++;
        if (oldest_enc !== 4'h0) begin errors++; $display("FAIL reset_enc got %h exp 0", oldest_enc); end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_status count %0d empty %b full %b exp 0 1 0", count, empty, full);
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        logic [3:0] exp_vec;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            exp_vec   = 4'b0001 << i;
            #1;
            checks++;
            if (alloc_gnt !== 1'b1 || alloc_vec !== exp_vec) begin
                errors++; $display("FAIL fill_vec%0d got gnt %b vec %b exp 1 %b", i, alloc_gnt, alloc_vec, exp_vec);
            end
            tick();
        end
        #1;
        checks++;
        if (alloc_gnt !== 1'b0 || alloc_vec !== 4'b0000) begin
            errors++; $display("FAIL fill_deny got gnt %b vec %b exp 0 0000", alloc_gnt, alloc_vec);
        end
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || valid !== 4'b1111) begin
            errors++; $display("FAIL fill_status count %0d full %b valid %b exp 4 1 1111", count, full, valid);
        end
        alloc_req = 1'b0;
    endtask

    // Relies on the full state left by test_fill
    task automatic test_drain_order();
        logic [3:0] exp_o;
        mask[0]     = 4'b1111;
        pick_rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_o = 4'b0001 << i;
            #1;
            checks++;
            if (oldest_vld[0] !== 1'b1 || oldest[0] !== exp_o || oldest_enc[0] !== 2'(i)) begin
                errors++; $display("FAIL drain%0d got vld %b oldest %b enc %0d exp 1 %b %0d",
                                   i, oldest_vld[0], oldest[0], oldest_enc[0], exp_o, i);
            end
            tick();
        end
        #1;
        checks++;
        if (empty !== 1'b1 || oldest_vld !== 2'b00) begin
            errors++; $display("FAIL drain_empty got empty %b vld %b exp 1 00", empty, oldest_vld);
        end
        idle_inputs();
    endtask

    task automatic test_reuse_order();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        fill(4);
        dealloc = 4'b0001;
        tick();
        dealloc   = '0;
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_vec !== 4'b0001) begin errors++; $display("FAIL reuse_vec got %b exp 0001", alloc_vec); end
        tick();
        alloc_req   = 1'b0;
        mask[0]     = 4'b1111;
        pick_rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (oldest[0] !== exp_seq[i]) begin
                errors++; $display("FAIL reuse_order%0d got %b exp %b", i, oldest[0], exp_seq[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_two_channels();
        do_reset();
        fill(4);
        mask = {4'b1111, 4'b1111};
        #1;
        checks++;
        if (oldest[0] !== 4'b0001 || oldest[1] !== 4'b0010 || oldest_enc !== {2'd1, 2'd0}) begin
            errors++; $display("FAIL two_ch_sel got %b %b enc %h exp 0001 0010 enc 4", oldest[0], oldest[1], oldest_enc);
        end
        pick_rdy = 2'b11;
        tick();
        pick_rdy = 2'b00;
        #1;
        checks++;
        if (count !== 3'd2 || valid !== 4'b1100) begin
            errors++; $display("FAIL two_ch_count got %0d valid %b exp 2 1100", count, valid);
        end
        checks++;
        if (oldest[0] !== 4'b0100 || oldest[1] !== 4'b1000) begin
            errors++; $display("FAIL two_ch_next got %b %b exp 0100 1000", oldest[0], oldest[1]);
        end
        // Channel 0 claims slot 3, so channel 1 falls back to slot 2
        mask[0] = 4'b1000;
        mask[1] = 4'b1100;
        #1;
        checks++;
        if (oldest[0] !== 4'b1000 || oldest[1] !== 4'b0100) begin
            errors++; $display("FAIL mask_prio got %b %b exp 1000 0100", oldest[0], oldest[1]);
        end
        // Only an invalid slot eligible: no candidate
        mask[0] = 4'b0001;
        #1;
        checks++;
        if (oldest_vld[0] !== 1'b0 || oldest[0] !== 4'b0000 || oldest_enc[0] !== 2'd0) begin
            errors++; $display("FAIL mask_none got vld %b %b enc %0d exp 0 0000 0", oldest_vld[0], oldest[0], oldest_enc[0]);
        end
        // Dealloc of invalid slots is ignored
        mask    = '0;
        dealloc = 4'b0011;
        tick();
        dealloc = '0;
        #1;
        checks++;
        if (count !== 3'd2 || valid !== 4'b1100) begin
            errors++; $display("FAIL dealloc_invalid got %0d valid %b exp 2 1100", count, valid);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill(4);
        dealloc   = 4'b0100;
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_gnt !== 1'b0 || alloc_vec !== 4'b0000) begin
            errors++; $display("FAIL full_free_deny got gnt %b vec %b exp 0 0000", alloc_gnt, alloc_vec);
        end
        tick();
        dealloc = '0;
        #1;
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_vec !== 4'b0100 || count !== 3'd3) begin
            errors++; $display("FAIL refill got gnt %b vec %b count %0d exp 1 0100 3", alloc_gnt, alloc_vec, count);
        end
        // Alloc and pick in the same cycle: count holds at 3, reused slot 2 youngest
        mask[0]     = 4'b1111;
        pick_rdy[0] = 1'b1;
        tick();
        alloc_req = 1'b0;
        pick_rdy  = '0;
        #1;
        checks++;
        if (count !== 3'd3 || valid !== 4'b1110) begin
            errors++; $display("FAIL alloc_pick_count got %0d valid %b exp 3 1110", count, valid);
        end
        checks++;
        if (oldest[0] !== 4'b0010) begin errors++; $display("FAIL b2b_oldest got %b exp 0010", oldest[0]); end
        mask[0] = 4'b0101;
        #1;
        checks++;
        if (oldest[0] !== 4'b0100) begin errors++; $display("FAIL b2b_reused got %b exp 0100", oldest[0]); end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        fill(2);
        rst       = 1'b1;
        alloc_req = 1'b1;
        pick_rdy  = 2'b11;
        mask      = {4'b1111, 4'b1111};
        tick();
        rst       = 1'b0;
        alloc_req = 1'b0;
        pick_rdy  = 2'b00;
        #1;
        checks++;
        if (valid !== 4'b0000 || count !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL midop_reset got valid %b count %0d empty %b exp 0000 0 1", valid, count, empty);
        end
        checks++;
        if (oldest_vld !== 2'b00) begin errors++; $display("FAIL midop_vld got %b exp 00", oldest_vld); end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_fill();
        test_drain_order();
        test_reuse_order();
        test_two_channels();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
